dyuv_line_scheduler: RTL and testbench

DYUV_LINE_SCHEDULER -- requirements
Module: dyuv_line_scheduler

---
 rtl/dyuv_line_scheduler_pkg.sv | 33 +++
 rtl/dyuv_line_counter.sv | 36 +++
 rtl/dyuv_line_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_dyuv_line_scheduler.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyuv_line_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dyuv_line_scheduler_pkg
// Brief    : Shared video types for the DYUV line scheduler and its counter.
// Revision : 1.0
// ============================================================================
package dyuv_line_scheduler_pkg;

    localparam int unsigned LINE_CNT_W = 9;

    typedef logic [LINE_CNT_W-1:0] line_cnt_t;

    localparam line_cnt_t WORDS_DEFAULT = 9'd384;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_s;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // A programmed length of zero falls back to the fixed default.
    function automatic line_cnt_t sel_line_len(input line_cnt_t wpl, input line_cnt_t dflt);
        return (wpl == '0) ? dflt : wpl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dyuv_line_counter.sv
`default_nettype none
// ============================================================================
// Module   : dyuv_line_counter
// Brief    : 9-bit line byte counter with load, saturating decrement, zero flag.
// Revision : 1.0
// ============================================================================
module dyuv_line_counter
    import dyuv_line_scheduler_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_load,
    input  line_cnt_t i_load_val,
    input  logic      i_dec,
    output line_cnt_t o_count,
    output logic      o_zero
);

    line_cnt_t r_count;

    // Load wins over decrement so a new line always starts from a full count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dyuv_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dyuv_line_scheduler
// Brief    : Arbitrates two DYUV planes onto one decoder, one line at a time.
// Revision : 1.0
// ============================================================================
module dyuv_line_scheduler
    import dyuv_line_scheduler_pkg::*;
#(
    parameter int unsigned WORDS_DEFAULT = dyuv_line_scheduler_pkg::WORDS_DEFAULT,
    parameter bit          FIRST_PRIO    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [23:0] start_yuv_a,
    input  logic [23:0] start_yuv_b,
    input  logic [8:0]  words_per_line,
    input  logic [7:0]  src_a_pixel,
    input  logic [7:0]  src_b_pixel,
    input  logic        src_a_write,
    input  logic        src_b_write,
    output logic        src_a_strobe,
    output logic        src_b_strobe,
    output logic        dec_reset,
    output logic [23:0] dec_start_yuv,
    output logic [7:0]  dec_pixel,
    output logic        dec_write,
    input  logic        dec_strobe,
    output logic        grant_b,
    output logic        busy,
    output logic        overrun
);

    localparam line_cnt_t c_words_default = line_cnt_t'(WORDS_DEFAULT);

    state_e    r_state;
    state_e    w_next_state;
    logic      r_prio;
    logic      r_grant_b;
    yuv_s      r_start_yuv;
    logic      r_overrun;

    logic      w_req_any;
    logic      w_req_both;
    logic      w_new_grant_b;
    logic      w_load;
    logic      w_run;
    logic      w_gnt_write;
    logic      w_dec_write;
    logic      w_handshake;
    logic      w_final_hs;
    logic      w_overrun;
    logic      w_cnt_zero;
    line_cnt_t w_count;
    line_cnt_t w_load_val;
    logic      w_dec_reset;
    logic      w_busy;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req_any  = req_a | req_b;
    assign w_req_both = req_a & req_b;
    assign w_load     = line_start & w_req_any;
    assign w_load_val = sel_line_len(words_per_line, c_words_default);

    always_comb begin
        w_new_grant_b = r_grant_b;
        if (w_req_both) begin
            w_new_grant_b = r_prio;
        end else if (req_b) begin
            w_new_grant_b = 1'b1;
        end else if (req_a) begin
            w_new_grant_b = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Byte path and handshake
    // ------------------------------------------------------------------
    assign w_run       = (r_state == ST_RUN);
    assign w_gnt_write = r_grant_b ? src_b_write : src_a_write;
    // Once the count is exhausted the decoder sees no more bytes this line.
    assign w_dec_write = w_run & ~w_cnt_zero & w_gnt_write;
    assign w_handshake = w_dec_write & dec_strobe;
    assign w_final_hs  = w_handshake & (w_count == line_cnt_t'(1));
    assign w_overrun   = line_start & w_run & ~w_cnt_zero & ~w_final_hs;

    dyuv_line_counter u_line_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_handshake),
        .o_count    (w_count),
        .o_zero     (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_dec_reset  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_IDLE;
            end
            ST_LOAD: begin
                w_dec_reset  = 1'b1;
                w_busy       = 1'b1;
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_cnt_zero) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (line_start) begin
            w_next_state = w_req_any ? ST_LOAD : ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Line-start registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio      <= FIRST_PRIO;
            r_grant_b   <= 1'b0;
            r_start_yuv <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            if (w_load) begin
                r_grant_b   <= w_new_grant_b;
                r_start_yuv <= yuv_s'(w_new_grant_b ? start_yuv_b : start_yuv_a);
                if (w_req_both) begin
                    r_prio <= ~r_prio;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The plane not feeding the decoder is drained so both fetchers stay
    // aligned to the display line; nothing is consumed while in reset.
    always_comb begin
        src_a_strobe = src_a_write;
        src_b_strobe = src_b_write;
        if (w_run) begin
            if (r_grant_b) begin
                src_b_strobe = w_handshake;
            end else begin
                src_a_strobe = w_handshake;
            end
        end
        if (reset) begin
            src_a_strobe = 1'b0;
            src_b_strobe = 1'b0;
        end
    end

    assign dec_pixel     = r_grant_b ? src_b_pixel : src_a_pixel;
    assign dec_write     = w_dec_write;
    assign dec_reset     = w_dec_reset;
    assign dec_start_yuv = r_start_yuv;
    assign grant_b       = r_grant_b;
    assign busy          = w_busy;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dyuv_line_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dyuv_line_scheduler
// Brief    : Scoreboard bench for dyuv_line_scheduler (byte order and framing).
// Revision : 1.0
// ============================================================================
module tb_dyuv_line_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [23:0] start_yuv_a = 24'h0;
    logic [23:0] start_yuv_b = 24'h0;
    logic [8:0]  words_per_line = 9'd0;
    logic [7:0]  src_a_pixel;
    logic [7:0]  src_b_pixel;
    logic        src_a_write = 1'b0;
    logic        src_b_write = 1'b0;
    logic        src_a_strobe;
    logic        src_b_strobe;
    logic        dec_reset;
    logic [23:0] dec_start_yuv;
    logic [7:0]  dec_pixel;
    logic        dec_write;
    logic        dec_strobe = 1'b0;
    logic        grant_b;
    logic        busy;
    logic        overrun;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_count = 0;
    logic [7:0]  a_seq = 8'h00;
    logic [7:0]  b_seq = 8'h80;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_e;
    bit          chk_drain = 1'b0;
    bit          exp_gb = 1'b0;
    bit          m_prio = 1'b0;

    assign src_a_pixel = a_seq;
    assign src_b_pixel = b_seq;

    always #5 clk = ~clk;

    dyuv_line_scheduler #(
        .WORDS_DEFAULT (384),
        .FIRST_PRIO    (1'b0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .line_start     (line_start),
        .req_a          (req_a),
        .req_b          (req_b),
        .start_yuv_a    (start_yuv_a),
        .start_yuv_b    (start_yuv_b),
        .words_per_line (words_per_line),
        .src_a_pixel    (src_a_pixel),
        .src_b_pixel    (src_b_pixel),
        .src_a_write    (src_a_write),
        .src_b_write    (src_b_write),
        .src_a_strobe   (src_a_strobe),
        .src_b_strobe   (src_b_strobe),
        .dec_reset      (dec_reset),
        .dec_start_yuv  (dec_start_yuv),
        .dec_pixel      (dec_pixel),
        .dec_write      (dec_write),
        .dec_strobe     (dec_strobe),
        .grant_b        (grant_b),
        .busy           (busy),
        .overrun        (overrun)
    );

    // Monitor: scoreboard pop on every decoder handshake, then source advance.
    always @(negedge clk) begin
        if (!reset) begin
            if (dec_write && dec_strobe) begin
                hs_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stray_handshake: consumed byte %h, required no handshake", dec_pixel);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dec_pixel !== mon_e) begin
                        n_fail++;
                        $display("FAIL byte_order: got %h, required %h", dec_pixel, mon_e);
                    end
                end
            end
            if (chk_drain) begin
                n_checks++;
                if (exp_gb ? (src_a_strobe !== src_a_write) : (src_b_strobe !== src_b_write)) begin
                    n_fail++;
                    $display("FAIL ungranted_drain: strobe a=%b b=%b, required write a=%b b=%b",
                             src_a_strobe, src_b_strobe, src_a_write, src_b_write);
                end
            end
        end
        if (src_a_write && src_a_strobe) a_seq = a_seq + 8'd1;
        if (src_b_write && src_b_strobe) b_seq = b_seq + 8'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ls(input bit ra, input bit rb, input logic [8:0] wpl);
        bit gb;
        gb = exp_gb;
        if (ra && rb) begin
            gb     = m_prio;
            m_prio = ~m_prio;
        end else if (ra || rb) begin
            gb = rb;
        end
        line_start     = 1'b1;
        req_a          = ra;
        req_b          = rb;
        words_per_line = wpl;
        tick();
        exp_gb     = gb;
        line_start = 1'b0;
        req_a      = 1'b0;
        req_b      = 1'b0;
    endtask

    task automatic push_line(input int n);
        logic [7:0] s;
        s = exp_gb ? b_seq : a_seq;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s);
            s = s + 8'd1;
        end
    endtask

    task automatic wait_q_empty(input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d bytes outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, grant_b, dec_reset, overrun, dec_write} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/grant_b/dec_reset/overrun/dec_write=%b, required 00000",
                     {busy, grant_b, dec_reset, overrun, dec_write});
        end
        n_checks++;
        if (dec_start_yuv !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_yuv: got %h, required 000000", dec_start_yuv);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_default_line();
        int h0;
        src_a_write = 1'b1;
        src_b_write = 1'b1;
        start_yuv_a = 24'h108080;
        start_yuv_b = 24'h2040c0;
        dec_strobe  = 1'b0;
        h0 = hs_count;
        pulse_ls(1'b1, 1'b0, 9'd0);
        n_checks++;
        if ({dec_reset, busy, dec_write, grant_b} !== 4'b1100) begin
            n_fail++;
            $display("FAIL default_load: dec_reset/busy/dec_write/grant_b=%b, required 1100",
                     {dec_reset, busy, dec_write, grant_b});
        end
        n_checks++;
        if (dec_start_yuv !== 24'h108080) begin
            n_fail++;
            $display("FAIL default_yuv: got %h, required 108080", dec_start_yuv);
        end
        tick();
        n_checks++;
        if (dec_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL default_reset_pulse: dec_reset=%b in cycle 2, required 0", dec_reset);
        end
        push_line(384);
        dec_strobe = 1'b1;
        wait_q_empty(450, "default");
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL default_idle: busy=%b, required 0", busy);
        end
        n_checks++;
        if (hs_count - h0 !== 384) begin
            n_fail++;
            $display("FAIL default_count: %0d handshakes, required 384", hs_count - h0);
        end
        dec_strobe = 1'b0;
    endtask

    task automatic test_arbitration();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_prio = 1'b0;
        exp_gb = 1'b0;
        tick();
        chk_drain = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pulse_ls(1'b1, 1'b1, 9'd4);
            n_checks++;
            if (grant_b !== (k == 1)) begin
                n_fail++;
                $display("FAIL arb_grant_line%0d: got %b, required %b", k, grant_b, (k == 1));
            end
            n_checks++;
            if (dec_start_yuv !== ((k == 1) ? 24'h2040c0 : 24'h108080)) begin
                n_fail++;
                $display("FAIL arb_yuv_line%0d: got %h, required %h", k, dec_start_yuv,
                         (k == 1) ? 24'h2040c0 : 24'h108080);
            end
            tick();
            push_line(4);
            dec_strobe = 1'b1;
            wait_q_empty(40, "arb");
            dec_strobe = 1'b0;
            tick();
        end
        chk_drain = 1'b0;
    endtask

    task automatic test_overrun();
        int h0;
        pulse_ls(1'b1, 1'b0, 9'd10);
        tick();
        push_line(6);
        dec_strobe = 1'b1;
        wait_q_empty(40, "overrun_first");
        dec_strobe = 1'b0;
        pulse_ls(1'b1, 1'b0, 9'd10);
        n_checks++;
        if ({overrun, dec_reset} !== 2'b11) begin
            n_fail++;
            $display("FAIL overrun_pulse: overrun/dec_reset=%b, required 11", {overrun, dec_reset});
        end
        tick();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_width: overrun=%b one cycle later, required 0", overrun);
        end
        h0 = hs_count;
        push_line(10);
        dec_strobe = 1'b1;
        wait_q_empty(60, "overrun_reload");
        tick();
        tick();
        n_checks++;
        if ((hs_count - h0 !== 10) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL overrun_reload: %0d handshakes busy=%b, required 10 and 0", hs_count - h0, busy);
        end
        dec_strobe = 1'b0;
    endtask

    task automatic test_coincide();
        int h0;
        pulse_ls(1'b1, 1'b0, 9'd10);
        tick();
        push_line(10);
        dec_strobe = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 1; i++) tick();
        pulse_ls(1'b1, 1'b0, 9'd10);
        n_checks++;
        if ({overrun, dec_reset} !== 2'b01) begin
            n_fail++;
            $display("FAIL coincide_flags: overrun/dec_reset=%b, required 01", {overrun, dec_reset});
        end
        tick();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_overrun_late: overrun=%b, required 0", overrun);
        end
        h0 = hs_count;
        push_line(10);
        wait_q_empty(60, "coincide");
        tick();
        tick();
        n_checks++;
        if ((hs_count - h0 !== 10) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL coincide_line: %0d handshakes busy=%b, required 10 and 0", hs_count - h0, busy);
        end
        dec_strobe = 1'b0;
    endtask

    task automatic test_random_strobe();
        int h0;
        pulse_ls(1'b0, 1'b1, 9'd16);
        n_checks++;
        if (grant_b !== 1'b1) begin
            n_fail++;
            $display("FAIL random_grant: got %b, required 1", grant_b);
        end
        tick();
        h0 = hs_count;
        push_line(16);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            dec_strobe = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_timeout: %0d bytes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        for (int i = 0; i < 8; i++) begin
            dec_strobe = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++;
        if ((hs_count - h0 !== 16) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL random_count: %0d handshakes busy=%b, required 16 and 0", hs_count - h0, busy);
        end
        dec_strobe = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int h0;
        pulse_ls(1'b0, 1'b1, 9'd50);
        tick();
        push_line(50);
        dec_strobe = 1'b1;
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, grant_b, dec_reset, overrun, dec_write, src_a_strobe, src_b_strobe} !== 7'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_flags: busy/grant_b/dec_reset/overrun/dec_write/stb_a/stb_b=%b, required 0000000",
                     {busy, grant_b, dec_reset, overrun, dec_write, src_a_strobe, src_b_strobe});
        end
        n_checks++;
        if (dec_start_yuv !== 24'h0) begin
            n_fail++;
            $display("FAIL midrun_reset_yuv: got %h, required 000000", dec_start_yuv);
        end
        exp_q.delete();
        m_prio = 1'b0;
        exp_gb = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        h0 = hs_count;
        repeat (10) tick();
        n_checks++;
        if ((hs_count - h0 !== 0) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL midrun_after: %0d handshakes busy=%b, required 0 and 0", hs_count - h0, busy);
        end
        n_checks++;
        if ({src_a_strobe, src_b_strobe} !== {src_a_write, src_b_write}) begin
            n_fail++;
            $display("FAIL midrun_drain: strobes=%b, required %b",
                     {src_a_strobe, src_b_strobe}, {src_a_write, src_b_write});
        end
        dec_strobe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_arbitration();
        test_overrun();
        test_coincide();
        test_random_strobe();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
